// File: rtl/mips_core_pkg.sv
// Shared core types: register widths, active list entry layout
// and the active list rollback state.
package mips_core_pkg;

  localparam int ACTIVE_LIST_DEPTH = 32;

  typedef logic [5:0] PhysReg;
  typedef logic [4:0] LogReg;

  typedef struct packed {
    LogReg  logical;
    PhysReg new_phys;
    PhysReg prev_phys;
    logic   has_dest;
  } active_list_entry_t;

  typedef enum logic {
    AL_NORMAL,
    AL_ROLLBACK
  } al_state_e;

endpackage

// File: rtl/active_list.sv
// In-order active list: allocates behind rename, retires the
// oldest done entry, and walks back youngest-first on a flush.
module active_list
  import mips_core_pkg::*;
#(
  parameter int DEPTH = ACTIVE_LIST_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  output logic             alloc_ready,
  input  logic             alloc_has_dest,
  input  logic [4:0]       alloc_logical,
  input  logic [5:0]       alloc_new_phys,
  input  logic [5:0]       alloc_prev_phys,
  output logic [PTR_W-1:0] alloc_tag,
  input  logic             wb_valid,
  input  logic [PTR_W-1:0] wb_tag,
  output logic             commit_valid,
  output logic             commit_free_valid,
  output logic [4:0]       commit_logical,
  output logic [5:0]       commit_free_phys,
  input  logic             flush_req,
  input  logic [PTR_W-1:0] flush_tag,
  output logic             busy,
  output logic             restore_valid,
  output logic [4:0]       restore_logical,
  output logic [5:0]       restore_phys,
  output logic             release_valid,
  output logic [5:0]       release_phys,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full
);

  al_state_e state, state_nx;

  logic [PTR_W:0]   head, tail;
  logic [PTR_W-1:0] head_idx, tail_idx;
  logic [PTR_W-1:0] walk_idx, stop_tag, stop_nx;
  logic [DEPTH-1:0] done;

  active_list_entry_t mem [DEPTH];
  active_list_entry_t head_e, walk_e, new_e;

  logic is_norm, is_empty, is_full;
  logic do_commit, do_alloc, do_flush;
  logic walk_last;

  assign head_idx = head[PTR_W-1:0];
  assign tail_idx = tail[PTR_W-1:0];
  assign walk_idx = tail_idx - 1'b1;
  assign stop_nx  = stop_tag + 1'b1;

  assign is_norm  = (state == AL_NORMAL);
  assign is_empty = (head == tail);
  assign is_full  = (head_idx == tail_idx) &&
                    (head[PTR_W] != tail[PTR_W]);

  assign head_e = mem[head_idx];
  assign walk_e = mem[walk_idx];

  assign do_commit = is_norm & ~is_empty & done[head_idx];
  assign do_flush  = is_norm & flush_req &
                     (walk_idx != flush_tag);
  // A flush in the same cycle squashes the incoming instr too.
  assign do_alloc  = rst_n & is_norm & ~is_full &
                     alloc_valid & ~flush_req;
  assign walk_last = (walk_idx == stop_nx);

  assign new_e = '{
    logical:   alloc_logical,
    new_phys:  alloc_new_phys,
    prev_phys: alloc_prev_phys,
    has_dest:  alloc_has_dest
  };

  always_ff @(posedge clk) begin
    if (!rst_n) state <= AL_NORMAL;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      AL_NORMAL:   if (do_flush)  state_nx = AL_ROLLBACK;
      AL_ROLLBACK: if (walk_last) state_nx = AL_NORMAL;
      default:     state_nx = AL_NORMAL;
    endcase
  end

  always_comb begin
    alloc_ready       = 1'b0;
    alloc_tag         = '0;
    commit_valid      = 1'b0;
    commit_free_valid = 1'b0;
    commit_logical    = '0;
    commit_free_phys  = '0;
    busy              = 1'b0;
    restore_valid     = 1'b0;
    restore_logical   = '0;
    restore_phys      = '0;
    release_valid     = 1'b0;
    release_phys      = '0;
    count             = '0;
    empty             = 1'b0;
    full              = 1'b0;
    if (rst_n) begin
      alloc_ready       = is_norm & ~is_full;
      alloc_tag         = tail_idx;
      commit_valid      = do_commit;
      commit_free_valid = do_commit & head_e.has_dest;
      if (do_commit) begin
        commit_logical   = head_e.logical;
        commit_free_phys = head_e.prev_phys;
      end
      busy          = ~is_norm;
      restore_valid = ~is_norm & walk_e.has_dest;
      release_valid = ~is_norm & walk_e.has_dest;
      if (restore_valid) begin
        restore_logical = walk_e.logical;
        restore_phys    = walk_e.prev_phys;
        release_phys    = walk_e.new_phys;
      end
      count = tail - head;
      empty = is_empty;
      full  = is_full;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      done     <= '0;
      stop_tag <= '0;
    end else begin
      if (wb_valid)  done[wb_tag] <= 1'b1;
      if (do_commit) head <= head + 1'b1;
      if (do_flush)  stop_tag <= flush_tag;
      if (do_alloc) begin
        done[tail_idx] <= 1'b0;
        tail           <= tail + 1'b1;
      end else if (!is_norm) begin
        tail <= tail - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_alloc) mem[tail_idx] <= new_e;
  end

endmodule

// File: tb/tb_active_list.sv
// Bench for active_list: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_active_list;
  import mips_core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       alloc_valid, alloc_ready, alloc_has_dest;
  logic [4:0] alloc_logical;
  logic [5:0] alloc_new_phys, alloc_prev_phys;
  logic [4:0] alloc_tag;
  logic       wb_valid;
  logic [4:0] wb_tag;
  logic       commit_valid, commit_free_valid;
  logic [4:0] commit_logical;
  logic [5:0] commit_free_phys;
  logic       flush_req;
  logic [4:0] flush_tag;
  logic       busy, restore_valid, release_valid;
  logic [4:0] restore_logical;
  logic [5:0] restore_phys, release_phys;
  logic [5:0] count;
  logic       empty, full;

  active_list dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_has_dest(alloc_has_dest),
    .alloc_logical(alloc_logical),
    .alloc_new_phys(alloc_new_phys),
    .alloc_prev_phys(alloc_prev_phys),
    .alloc_tag(alloc_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag),
    .commit_valid(commit_valid),
    .commit_free_valid(commit_free_valid),
    .commit_logical(commit_logical),
    .commit_free_phys(commit_free_phys),
    .flush_req(flush_req), .flush_tag(flush_tag),
    .busy(busy),
    .restore_valid(restore_valid),
    .restore_logical(restore_logical),
    .restore_phys(restore_phys),
    .release_valid(release_valid),
    .release_phys(release_phys),
    .count(count), .empty(empty), .full(full)
  );

  typedef struct {
    int tag; int lg; int np; int pp; bit hd;
  } ent_t;

  ent_t q[$];
  bit   dn[32];
  int   tl;
  bit   mb;
  int   mstop;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic compare();
    int ar, at, cv, cfv, cl, cp, by;
    int rv, rl, rp, lp, cnt, em, fu;
    ar = 0; at = 0; cv = 0; cfv = 0; cl = 0; cp = 0; by = 0;
    rv = 0; rl = 0; rp = 0; lp = 0; cnt = 0; em = 0; fu = 0;
    if (rst_n) begin
      cnt = q.size();
      em  = (cnt == 0);
      fu  = (cnt == 32);
      ar  = !mb && !fu;
      at  = tl % 32;
      by  = mb;
      if (!mb && cnt > 0 && dn[q[0].tag]) begin
        cv  = 1;
        cfv = q[0].hd;
        cl  = q[0].lg;
        cp  = q[0].pp;
      end
      if (mb && cnt > 0 && q[$].hd) begin
        rv = 1;
        rl = q[$].lg;
        rp = q[$].pp;
        lp = q[$].np;
      end
    end
    chk("alloc_ready", int'(alloc_ready), ar);
    chk("alloc_tag", int'(alloc_tag), at);
    chk("commit_valid", int'(commit_valid), cv);
    chk("commit_free_valid", int'(commit_free_valid), cfv);
    chk("commit_logical", int'(commit_logical), cl);
    chk("commit_free_phys", int'(commit_free_phys), cp);
    chk("busy", int'(busy), by);
    chk("restore_valid", int'(restore_valid), rv);
    chk("restore_logical", int'(restore_logical), rl);
    chk("restore_phys", int'(restore_phys), rp);
    chk("release_valid", int'(release_valid), rv);
    chk("release_phys", int'(release_phys), lp);
    chk("count", int'(count), cnt);
    chk("empty", int'(empty), em);
    chk("full", int'(full), fu);
  endtask

  task automatic apply_model();
    bit   cv, rdy;
    int   last;
    ent_t e;
    if (!rst_n) begin
      q.delete();
      tl = 0; mb = 0; mstop = 0;
      foreach (dn[i]) dn[i] = 0;
      return;
    end
    cv  = !mb && q.size() > 0 && dn[q[0].tag];
    rdy = !mb && q.size() < 32;
    if (wb_valid) dn[wb_tag] = 1;
    if (!mb) begin
      last = ((tl + 63) % 64) % 32;
      if (cv) void'(q.pop_front());
      if (flush_req) begin
        if (last != int'(flush_tag)) begin
          mb = 1;
          mstop = flush_tag;
        end
      end else if (alloc_valid && rdy) begin
        e.tag = tl % 32;
        e.lg  = alloc_logical;
        e.np  = alloc_new_phys;
        e.pp  = alloc_prev_phys;
        e.hd  = alloc_has_dest;
        q.push_back(e);
        dn[e.tag] = 0;
        tl = (tl + 1) % 64;
      end
    end else begin
      e  = q.pop_back();
      tl = (tl + 63) % 64;
      if (e.tag == (mstop + 1) % 32) mb = 0;
    end
  endtask

  task automatic tick();
    apply_model();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_has_dest = 0;
    alloc_logical = 0; alloc_new_phys = 0;
    alloc_prev_phys = 0;
    wb_valid = 0; wb_tag = 0;
    flush_req = 0; flush_tag = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    #1;
  endtask

  task automatic put(input int lg, input int np,
                     input int pp, input bit hd);
    alloc_valid = 1;
    alloc_logical = 5'(lg);
    alloc_new_phys = 6'(np);
    alloc_prev_phys = 6'(pp);
    alloc_has_dest = hd;
    tick();
    alloc_valid = 0;
  endtask

  task automatic wb(input int t);
    wb_valid = 1;
    wb_tag = 5'(t);
    tick();
    wb_valid = 0;
  endtask

  task automatic flush(input int t);
    flush_req = 1;
    flush_tag = 5'(t);
    tick();
    flush_req = 0;
  endtask

  initial begin
    idle();
    rst_n = 0;
    @(negedge clk);
    tick();
    chk("rst alloc_ready", int'(alloc_ready), 0);
    tick();
    rst_n = 1;
    #1;
    chk("post rst alloc_ready", int'(alloc_ready), 1);
    chk("post rst empty", int'(empty), 1);
    chk("post rst count", int'(count), 0);

    chk("tag0", int'(alloc_tag), 0);
    put(1, 32, 1, 1);
    chk("tag1", int'(alloc_tag), 1);
    put(2, 33, 2, 1);
    chk("tag2", int'(alloc_tag), 2);
    put(3, 0, 0, 0);
    chk("t1 count", int'(count), 3);
    chk("t1 no commit", int'(commit_valid), 0);

    wb(1);
    chk("t2 wait head", int'(commit_valid), 0);
    wb(0);
    chk("t2 c0 valid", int'(commit_valid), 1);
    chk("t2 c0 logical", int'(commit_logical), 1);
    chk("t2 c0 free", int'(commit_free_phys), 1);
    tick();
    chk("t2 c1 valid", int'(commit_valid), 1);
    chk("t2 c1 logical", int'(commit_logical), 2);
    chk("t2 c1 free", int'(commit_free_phys), 2);
    tick();
    chk("t2 tag2 waits", int'(commit_valid), 0);
    wb(2);
    chk("t2 c2 valid", int'(commit_valid), 1);
    chk("t2 c2 no free", int'(commit_free_valid), 0);
    tick();

    for (int i = 0; i < 32; i++) begin
      chk("t3 fill tag", int'(alloc_tag), (3 + i) % 32);
      put(i % 32, (i + 7) % 64, (i + 19) % 64, 1);
    end
    chk("t3 full", int'(full), 1);
    chk("t3 not ready", int'(alloc_ready), 0);
    alloc_valid = 1;
    wb(3);
    alloc_valid = 1;
    chk("t3 commit", int'(commit_valid), 1);
    chk("t3 no bypass", int'(alloc_ready), 0);
    tick();
    alloc_valid = 0;
    chk("t3 ready again", int'(alloc_ready), 1);
    chk("t3 tail idx", int'(alloc_tag), 3);
    chk("t3 count", int'(count), 31);

    do_reset();
    for (int i = 0; i < 5; i++) put(i + 1, 40 + i, 10 + i, 1);
    flush(1);
    chk("t4 busy", int'(busy), 1);
    chk("t4 ready", int'(alloc_ready), 0);
    chk("t4 r4 phys", int'(restore_phys), 14);
    chk("t4 r4 logical", int'(restore_logical), 5);
    chk("t4 r4 release", int'(release_phys), 44);
    tick();
    chk("t4 r3 phys", int'(restore_phys), 13);
    tick();
    chk("t4 r2 phys", int'(restore_phys), 12);
    chk("t4 r2 release", int'(release_phys), 42);
    tick();
    chk("t4 done busy", int'(busy), 0);
    chk("t4 count", int'(count), 2);
    chk("t4 ready", int'(alloc_ready), 1);

    flush(1);
    chk("t5 noop busy", int'(busy), 0);
    chk("t5 noop count", int'(count), 2);
    wb(0);
    chk("t5 commit", int'(commit_valid), 1);
    flush(0);
    chk("t5 busy", int'(busy), 1);
    chk("t5 r1 phys", int'(restore_phys), 11);
    chk("t5 count", int'(count), 1);
    tick();
    chk("t5 idle", int'(busy), 0);
    chk("t5 empty", int'(empty), 1);

    for (int i = 0; i < 5; i++) put(i + 8, 50 + i, 20 + i, 1);
    flush(3);
    tick();
    chk("t6 busy", int'(busy), 1);
    rst_n = 0;
    #1;
    chk("t6 rst busy", int'(busy), 0);
    tick();
    rst_n = 1;
    #1;
    chk("t6 empty", int'(empty), 1);
    chk("t6 busy", int'(busy), 0);
    chk("t6 restore", int'(restore_valid), 0);
    chk("t6 release", int'(release_valid), 0);
    chk("t6 count", int'(count), 0);
    tick();

    for (int n = 0; n < 4000; n++) begin
      idle();
      rst_n = ($urandom % 500) != 0;
      alloc_valid = ($urandom % 10) < 6;
      alloc_has_dest = ($urandom % 4) != 0;
      alloc_logical = 5'($urandom);
      alloc_new_phys = 6'($urandom);
      alloc_prev_phys = 6'($urandom);
      if (q.size() > 0 && ($urandom % 3) == 0) begin
        wb_valid = 1;
        wb_tag = 5'(q[$urandom % q.size()].tag);
      end else if (($urandom % 20) == 0) begin
        wb_valid = 1;
        wb_tag = 5'($urandom);
      end
      if (!mb && q.size() > 0 && ($urandom % 25) == 0) begin
        flush_req = 1;
        flush_tag = 5'(q[$urandom % q.size()].tag);
      end else if (mb && ($urandom % 8) == 0) begin
        flush_req = 1;
        flush_tag = 5'($urandom);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
